// File: rtl/huffman_canon_decoder_if.sv
// Configuration, serial-bit and decoded-symbol signals of the canonical Huffman decoder.
// The master side programs the tables and feeds bits; the slave side is the decoder.
interface huffman_canon_decoder_if #(
  parameter int unsigned SYM_W   = 6,
  parameter int unsigned MAX_LEN = 8
);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic             cfg_we;
  logic             cfg_sel;
  logic [SYM_W-1:0] cfg_addr;
  logic [SYM_W:0]   cfg_data;
  logic             en;
  logic             e;
  logic             e_valid;
  logic [SYM_W-1:0] s;
  logic             s_valid;
  logic [LW-1:0]    s_len;
  logic             err;
  logic             busy;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data, en, e, e_valid,
    input  s, s_valid, s_len, err, busy
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data, en, e, e_valid,
    output s, s_valid, s_len, err, busy
  );
endinterface

// File: rtl/huffman_canon_decoder.sv
// Bit-serial canonical Huffman decoder: one code bit per valid cycle, symbol registered
// on the edge that samples the final bit of each codeword.
module huffman_canon_decoder #(
  parameter int unsigned SYM_W   = 6,
  parameter int unsigned MAX_LEN = 8
) (
  input logic                    clk,
  input logic                    rst,
  huffman_canon_decoder_if.slave bus
);
  localparam int unsigned NSYM = 2 ** SYM_W;
  localparam int unsigned LW   = $clog2(MAX_LEN + 1);
  localparam int unsigned NLEN = 2 ** LW;
  localparam int unsigned CW   = MAX_LEN + 1;
  localparam int unsigned IW   = SYM_W + 1;
  localparam int unsigned DW   = ((CW > IW) ? CW : IW) + 1;

  // Count table is sized to the full length-index range; entry 0 is never written.
  logic [IW-1:0]    cnt_q [NLEN];
  logic [SYM_W-1:0] sym_q [NSYM];

  logic [LW-1:0]    len_q;
  logic [CW-1:0]    code_q;
  logic [CW-1:0]    first_q;
  logic [IW-1:0]    index_q;

  logic [SYM_W-1:0] s_q;
  logic             s_valid_q;
  logic [LW-1:0]    s_len_q;
  logic             err_q;

  logic [CW-1:0]    c;
  logic [CW-1:0]    diff;
  logic [CW-1:0]    first_sum;
  logic [CW-1:0]    first_nx;
  logic [LW-1:0]    l_nx;
  logic [IW-1:0]    cnt_l;
  logic [DW-1:0]    sym_pos;
  logic             hit;
  logic             oob;
  logic             at_max;

  always_comb begin
    c         = code_q | CW'(bus.e);
    l_nx      = len_q + LW'(1);
    cnt_l     = cnt_q[l_nx];
    diff      = c - first_q;
    hit       = DW'(diff) < DW'(cnt_l);
    sym_pos   = DW'(index_q) + DW'(diff);
    oob       = sym_pos >= DW'(NSYM);
    at_max    = (l_nx == LW'(MAX_LEN));
    first_sum = first_q + CW'(cnt_l);
    first_nx  = first_sum << 1;
  end

  // Tables are only writable while decoding is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NLEN); i++) cnt_q[i] <= '0;
      for (int i = 0; i < int'(NSYM); i++) sym_q[i] <= '0;
    end else if (bus.cfg_we && !bus.en) begin
      if (!bus.cfg_sel) begin
        if (bus.cfg_addr != '0 && 32'(bus.cfg_addr) <= MAX_LEN) begin
          cnt_q[LW'(bus.cfg_addr)] <= bus.cfg_data;
        end
      end else begin
        sym_q[bus.cfg_addr] <= bus.cfg_data[SYM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      code_q    <= '0;
      first_q   <= '0;
      index_q   <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      s_len_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      s_valid_q <= 1'b0;
      err_q     <= 1'b0;
      if (!bus.en) begin
        len_q   <= '0;
        code_q  <= '0;
        first_q <= '0;
        index_q <= '0;
      end else if (bus.e_valid) begin
        if (hit && !oob) begin
          s_q       <= sym_q[sym_pos[SYM_W-1:0]];
          s_len_q   <= l_nx;
          s_valid_q <= 1'b1;
          len_q     <= '0;
          code_q    <= '0;
          first_q   <= '0;
          index_q   <= '0;
        end else if (hit || at_max) begin
          // Match beyond the symbol table, or no match at the longest length.
          err_q   <= 1'b1;
          len_q   <= '0;
          code_q  <= '0;
          first_q <= '0;
          index_q <= '0;
        end else begin
          len_q   <= l_nx;
          code_q  <= c << 1;
          first_q <= first_nx;
          index_q <= index_q + cnt_l;
        end
      end
    end
  end

  assign bus.s       = s_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_len   = s_len_q;
  assign bus.err     = err_q;
  assign bus.busy    = (len_q != '0);

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Directed and randomized bench; expected outputs come from a codebook-lookup model.
module tb_huffman_canon_decoder;
  localparam int SYM_W   = 6;
  localparam int MAX_LEN = 8;
  localparam int NSYM    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  huffman_canon_decoder_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) bus ();

  huffman_canon_decoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int m_cnt [MAX_LEN+1];
  int m_sym [NSYM];
  int m_len, m_val;
  int e_s, e_slen;
  int e_sv, e_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Build the canonical codebook and look up (len, val): symbol, -1 no match, -2 past table.
  function automatic int lookup(int len, int val);
    int code = 0;
    int k = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int j = 0; j < m_cnt[l]; j++) begin
        if (l == len && code == val) return (k < NSYM) ? m_sym[k] : -2;
        code++;
        k++;
      end
      code = code * 2;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= MAX_LEN; i++) m_cnt[i] = 0;
    for (int i = 0; i < NSYM; i++) m_sym[i] = 0;
    m_len = 0; m_val = 0; e_s = 0; e_slen = 0; e_sv = 0; e_err = 0;
  endtask

  task automatic check_outputs(string tag);
    chk({tag, "_s"},       32'(bus.s), e_s);
    chk({tag, "_s_valid"}, 32'(bus.s_valid), e_sv);
    chk({tag, "_s_len"},   32'(bus.s_len), e_slen);
    chk({tag, "_err"},     32'(bus.err), e_err);
    chk({tag, "_busy"},    32'(bus.busy), (m_len != 0) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic tick(bit en, bit ev, bit eb, bit we, bit sel, int addr, int data);
    int r;
    bus.en = en; bus.e_valid = ev; bus.e = eb;
    bus.cfg_we = we; bus.cfg_sel = sel;
    bus.cfg_addr = 6'(addr); bus.cfg_data = 7'(data);
    @(posedge clk);
    e_sv = 0; e_err = 0;
    if (!en) begin
      if (we) begin
        if (!sel) begin
          if (addr != 0 && addr <= MAX_LEN) m_cnt[addr] = data;
        end else begin
          m_sym[addr] = data % NSYM;
        end
      end
      m_len = 0; m_val = 0;
    end else if (ev) begin
      m_len++;
      m_val = m_val * 2 + int'(eb);
      r = lookup(m_len, m_val);
      if (r >= 0) begin
        e_s = r; e_slen = m_len; e_sv = 1;
        m_len = 0; m_val = 0;
      end else if (r == -2 || m_len == MAX_LEN) begin
        e_err = 1;
        m_len = 0; m_val = 0;
      end
    end
    #1;
    check_outputs("tick");
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic bitc(bit b);
    tick(1'b1, 1'b1, b, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr(bit sel, int addr, int data);
    tick(1'b0, 1'b0, 1'b0, 1'b1, sel, addr, data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic program_std();
    wr(1'b0, 2, 3);
    wr(1'b0, 3, 2);
    wr(1'b1, 0, 5);
    wr(1'b1, 1, 9);
    wr(1'b1, 2, 12);
    wr(1'b1, 3, 33);
    wr(1'b1, 4, 63);
  endtask

  initial begin
    int freec, total, lim, cv;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.en = 1'b0; bus.e = 1'b0; bus.e_valid = 1'b0;
    @(negedge clk);
    do_reset();
    program_std();

    // 0,1 -> 9
    bitc(1'b0); bitc(1'b1);
    chk("s1_s", 32'(bus.s), 9);
    chk("s1_len", 32'(bus.s_len), 2);
    chk("s1_valid", 32'(bus.s_valid), 1);
    idle();
    chk("s1_drop", 32'(bus.s_valid), 0);

    // 111 then 110 back-to-back
    bitc(1'b1); bitc(1'b1); bitc(1'b1);
    chk("s2_s_a", 32'(bus.s), 63);
    chk("s2_len_a", 32'(bus.s_len), 3);
    bitc(1'b1); bitc(1'b1); bitc(1'b0);
    chk("s2_s_b", 32'(bus.s), 33);
    chk("s2_valid_b", 32'(bus.s_valid), 1);

    // gap mid-codeword
    bitc(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("s3_busy", 32'(bus.busy), 1);
    end
    bitc(1'b0);
    chk("s3_s", 32'(bus.s), 12);
    chk("s3_len", 32'(bus.s_len), 2);

    // en=0 clears partial codeword
    bitc(1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("s6_busy", 32'(bus.busy), 0);
    bitc(1'b0); bitc(1'b1);
    chk("s6_s", 32'(bus.s), 9);

    // writes with en=1 and to illegal count indices are dropped
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
    wr(1'b0, 0, 7);
    wr(1'b0, 9, 7);
    bitc(1'b0); bitc(1'b1);
    chk("s7_s", 32'(bus.s), 9);
    bitc(1'b1); bitc(1'b1); bitc(1'b0);
    chk("s7_s_b", 32'(bus.s), 33);

    // reset mid-codeword
    bitc(1'b1);
    do_reset();
    program_std();
    bitc(1'b0); bitc(1'b0);
    chk("s5_s", 32'(bus.s), 5);
    chk("s5_err", 32'(bus.err), 0);

    // empty tables: eight ones -> err
    do_reset();
    for (int i = 0; i < 7; i++) bitc(1'b1);
    chk("s4_err_early", 32'(bus.err), 0);
    bitc(1'b1);
    chk("s4_err", 32'(bus.err), 1);
    chk("s4_valid", 32'(bus.s_valid), 0);
    chk("s4_s", 32'(bus.s), 0);

    // random prefix-free tables and random bit streams
    for (int round = 0; round < 4; round++) begin
      freec = 2;
      total = 0;
      for (int l = 1; l <= MAX_LEN; l++) begin
        lim = (freec < NSYM - total) ? freec : NSYM - total;
        cv = int'($urandom_range(0, lim));
        wr(1'b0, l, cv);
        total += cv;
        freec = (freec - cv) * 2;
      end
      for (int k = 0; k < NSYM; k++) wr(1'b1, k, int'($urandom_range(0, 127)));
      for (int n = 0; n < 400; n++) begin
        tick(($urandom % 20) != 0, ($urandom % 4) != 0, 1'($urandom), 1'b0, 1'b0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
